// File: rtl/cache_pkg.sv
// Shared types and PLRU tree helpers for the N-way data cache.
package cache_pkg;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_RESP} state_t;

  localparam int PLRU_W      = 3;
  localparam int DEF_ADDR_W  = 19;
  localparam int DEF_SETS    = 64;
  localparam int DEF_LINE_W  = 2;
  localparam int DEF_IDX_W   = $clog2(DEF_SETS);
  localparam int DEF_OFF_W   = $clog2(DEF_LINE_W);
  localparam int DEF_TAG_W   = DEF_ADDR_W - DEF_IDX_W - DEF_OFF_W - 2;

  // Tree bits point at the LRU side: bit0 = root, bit1 = ways 0/1, bit2 = ways 2/3.
  // Two-way sets only use bit0.
  function automatic logic [PLRU_W-1:0] plru_update(input logic [PLRU_W-1:0] bits,
                                                    input logic [1:0] way, input int ways);
    logic [PLRU_W-1:0] nb;
    nb = bits;
    if (ways == 2) begin
      nb[0] = ~way[0];
    end else begin
      nb[0] = ~way[1];
      if (way[1]) nb[2] = ~way[0];
      else        nb[1] = ~way[0];
    end
    return nb;
  endfunction

  function automatic logic [1:0] plru_victim(input logic [PLRU_W-1:0] bits, input int ways);
    if (ways == 2) return {1'b0, bits[0]};
    return bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
  endfunction

endpackage

// File: rtl/cache_plru.sv
// Per-set pseudo-LRU state; one touch port, one combinational victim lookup.
module cache_plru
  import cache_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int WAYS  = 2,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = (WAYS > 2) ? 2 : 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             touch,
  input  logic [WAY_W-1:0] touch_way,
  input  logic [IDX_W-1:0] touch_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WAY_W-1:0] victim
);

  logic [SETS-1:0][PLRU_W-1:0] tree;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       tree <= '0;
    else if (touch) tree[touch_idx] <= plru_update(tree[touch_idx], 2'(touch_way), WAYS);
  end

  assign victim = WAY_W'(plru_victim(tree[rd_idx], WAYS));

endmodule

// File: rtl/cache_nway_ctrl.sv
// N-way set-associative data cache: read-allocate line fill, write-through no-allocate.
// Optional hit/miss counters enabled by defining CACHE_STATS_EN.
module cache_nway_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 2
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_wr_ack,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
  localparam int WAY_W = (WAYS > 2) ? 2 : 1;

  state_t state, state_n;

  logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
  logic [DATA_W-1:0] data_mem [WAYS][SETS*LINE_WORDS];
  logic [WAYS-1:0][SETS-1:0] valid;

  logic [OFF_W-1:0]  req_off, lat_off, beat;
  logic [IDX_W-1:0]  req_idx, lat_idx;
  logic [TAG_W-1:0]  req_tag, lat_tag;
  logic [ADDR_W-3:0] lat_waddr;
  logic [DATA_W-1:0] lat_wdata, rdata_q;
  logic [WAY_W-1:0]  hit_way, inv_way, plru_vic, fill_way;
  logic [WAYS-1:0]   way_hit;
  logic              hit, inv_found, accept, last_beat, resp_q, plru_touch;
  logic              unused_bits;

  assign req_off = req_addr[OFF_W+1:2];
  assign req_idx = req_addr[IDX_W+OFF_W+1:OFF_W+2];
  assign req_tag = req_addr[ADDR_W-1:IDX_W+OFF_W+2];
  assign lat_off = lat_waddr[OFF_W-1:0];
  assign lat_idx = lat_waddr[IDX_W+OFF_W-1:OFF_W];
  assign lat_tag = lat_waddr[ADDR_W-3:IDX_W+OFF_W];
  assign unused_bits = ^req_addr[1:0];

  assign accept    = req_valid && req_ready;
  assign last_beat = (beat == OFF_W'(LINE_WORDS-1));

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_hit[w] = valid[w][req_idx] && (tag_mem[w][req_idx] == req_tag);
  end
  assign hit = |way_hit;

  // Descending scan so the lowest-numbered match / invalid way wins.
  always_comb begin
    hit_way   = '0;
    inv_way   = '0;
    inv_found = 1'b0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (way_hit[w]) hit_way = WAY_W'(w);
      if (!valid[w][req_idx]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept && (req_we || !hit)) state_n = req_we ? S_WRITE : S_FILL;
      S_FILL:  if (mem_rvalid && last_beat)    state_n = S_RESP;
      S_WRITE: if (mem_wr_ack)                 state_n = S_RESP;
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid     <= '0;
      beat      <= '0;
      resp_q    <= 1'b0;
      rdata_q   <= '0;
      lat_waddr <= '0;
      lat_wdata <= '0;
      fill_way  <= '0;
    end else begin
      resp_q <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          lat_waddr <= req_addr[ADDR_W-1:2];
          lat_wdata <= req_wdata;
          fill_way  <= inv_found ? inv_way : plru_vic;
          if (!req_we && hit) begin
            resp_q  <= 1'b1;
            rdata_q <= data_mem[hit_way][{req_idx, req_off}];
          end
        end
        S_FILL: if (mem_rvalid) begin
          beat <= beat + OFF_W'(1);
          if (beat == lat_off) rdata_q <= mem_rdata;
          if (last_beat) begin
            valid[fill_way][lat_idx] <= 1'b1;
            resp_q <= 1'b1;
          end
        end
        S_WRITE: if (mem_wr_ack) begin
          resp_q  <= 1'b1;
          rdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Tag/data storage is not reset; validity alone gates hits.
  always_ff @(posedge clk) begin
    if (accept && req_we && hit) data_mem[hit_way][{req_idx, req_off}] <= req_wdata;
    if (state == S_FILL && mem_rvalid) begin
      data_mem[fill_way][{lat_idx, beat}] <= mem_rdata;
      if (last_beat) tag_mem[fill_way][lat_idx] <= lat_tag;
    end
  end

  assign plru_touch = (accept && hit) || (state == S_FILL && mem_rvalid && last_beat);

  cache_plru #(.SETS(SETS), .WAYS(WAYS), .IDX_W(IDX_W), .WAY_W(WAY_W)) u_plru (
    .clk       (clk),
    .rst       (rst),
    .touch     (plru_touch),
    .touch_way ((state == S_IDLE) ? hit_way : fill_way),
    .touch_idx ((state == S_IDLE) ? req_idx : lat_idx),
    .rd_idx    (req_idx),
    .victim    (plru_vic)
  );

  assign req_ready   = (state == S_IDLE);
  assign resp_valid  = resp_q;
  assign resp_rdata  = resp_q ? rdata_q : '0;
  assign mem_rd_req  = (state == S_FILL);
  assign mem_rd_addr = mem_rd_req ? {lat_waddr[ADDR_W-3:OFF_W], {(OFF_W+2){1'b0}}} : '0;
  assign mem_wr_req  = (state == S_WRITE);
  assign mem_wr_addr = mem_wr_req ? {lat_waddr, 2'b00} : '0;
  assign mem_wr_data = mem_wr_req ? lat_wdata : '0;

`ifdef CACHE_STATS_EN
  logic [31:0] hits, misses;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hits   <= '0;
      misses <= '0;
    end else if (accept) begin
      if (hit) begin
        if (hits != '1) hits <= hits + 32'd1;
      end else begin
        if (misses != '1) misses <= misses + 32'd1;
      end
    end
  end
  assign hit_cnt  = hits;
  assign miss_cnt = misses;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule
